// File: rtl/jtcontra_sched_pkg.sv
// Shared types and constants for the Contra ROM read scheduler.
// FSM states, slot count, slot indices and a width helper.
package jtcontra_sched_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT
  } sched_st_e;

  localparam int NSLOT = 4;
  localparam int GFX1  = 0;
  localparam int GFX2  = 1;
  localparam int SND   = 2;
  localparam int MAIN  = 3;

  function automatic int max4(int a, int b, int c, int d);
    int m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/jtcontra_rom_sched_if.sv
// Bus between the ROM clients / SDRAM controller and the scheduler.
// slave: scheduler side; master: clients and controller side.
interface jtcontra_rom_sched_if #(
  parameter int AW0 = 18,
  parameter int AW1 = 18,
  parameter int AW2 = 15,
  parameter int AW3 = 18
);
  logic           vblank;
  logic           downloading;
  logic           slot0_cs;
  logic           slot1_cs;
  logic           slot2_cs;
  logic           slot3_cs;
  logic [AW0-1:0] slot0_addr;
  logic [AW1-1:0] slot1_addr;
  logic [AW2-1:0] slot2_addr;
  logic [AW3-1:0] slot3_addr;
  logic [15:0]    slot0_dout;
  logic [15:0]    slot1_dout;
  logic [15:0]    slot2_dout;
  logic [15:0]    slot3_dout;
  logic           slot0_ok;
  logic           slot1_ok;
  logic           slot2_ok;
  logic           slot3_ok;
  logic           sdram_req;
  logic [21:0]    sdram_addr;
  logic           sdram_ack;
  logic           data_rdy;
  logic [31:0]    data_read;
  logic           refresh_en;

  modport slave (
    input  vblank, downloading,
    input  slot0_cs, slot1_cs,
    input  slot2_cs, slot3_cs,
    input  slot0_addr, slot1_addr,
    input  slot2_addr, slot3_addr,
    output slot0_dout, slot1_dout,
    output slot2_dout, slot3_dout,
    output slot0_ok, slot1_ok,
    output slot2_ok, slot3_ok,
    output sdram_req, sdram_addr,
    input  sdram_ack, data_rdy,
    input  data_read,
    output refresh_en
  );

  modport master (
    output vblank, downloading,
    output slot0_cs, slot1_cs,
    output slot2_cs, slot3_cs,
    output slot0_addr, slot1_addr,
    output slot2_addr, slot3_addr,
    input  slot0_dout, slot1_dout,
    input  slot2_dout, slot3_dout,
    input  slot0_ok, slot1_ok,
    input  slot2_ok, slot3_ok,
    input  sdram_req, sdram_addr,
    output sdram_ack, data_rdy,
    output data_read,
    input  refresh_en
  );
endinterface

// File: rtl/jtcontra_sched_slot.sv
// One-entry 32-bit cache for one ROM slot: hit compare, half select.
// Ports: clk, rst, clr, we, wr_tag, wr_data, cs, addr -> ok, dout, pend.
module jtcontra_sched_slot #(
  parameter int AW = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          we,
  input  logic [AW-2:0] wr_tag,
  input  logic [31:0]   wr_data,
  input  logic          cs,
  input  logic [AW-1:0] addr,
  output logic          ok,
  output logic [15:0]   dout,
  output logic          pend
);
  logic          valid;
  logic [AW-2:0] tag;
  logic [31:0]   data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid <= 1'b0;
      tag   <= '0;
      data  <= '0;
    end else if (clr) begin
      valid <= 1'b0;
    end else if (we) begin
      valid <= 1'b1;
      tag   <= wr_tag;
      data  <= wr_data;
    end
  end

  // clr also masks ok in the cycle it rises
  assign ok   = cs & valid & ~clr
              & (tag == addr[AW-1:1]);
  assign dout = addr[0] ? data[31:16]
                        : data[15:0];
  assign pend = cs & ~ok;
endmodule

// File: rtl/jtcontra_rom_sched.sv
// Four-slot SDRAM read scheduler with per-slot one-word caches.
// Ports: clk, rst, bus (slave). Define JTCONTRA_SCHED_RR_EN for GFX round-robin.
module jtcontra_rom_sched
  import jtcontra_sched_pkg::*;
#(
  parameter int          SLOT0_AW     = 18,
  parameter int          SLOT1_AW     = 18,
  parameter int          SLOT2_AW     = 15,
  parameter int          SLOT3_AW     = 18,
  parameter logic [21:0] SLOT0_OFFSET = 22'd0,
  parameter logic [21:0] SLOT1_OFFSET = 22'd0,
  parameter logic [21:0] SLOT2_OFFSET = 22'd0,
  parameter logic [21:0] SLOT3_OFFSET = 22'd0
) (
  input logic clk,
  input logic rst,
  jtcontra_rom_sched_if.slave bus
);
  localparam int TW = max4(SLOT0_AW, SLOT1_AW,
                           SLOT2_AW, SLOT3_AW) - 1;

  sched_st_e                  st;
  logic                       req_q;
  logic [21:0]                addr_q;
  logic [1:0]                 win_q;
  logic [TW-1:0]              tag_q;
  logic [1:0]                 win;
  logic                       gfx_pick;
  logic                       fill;
  logic [NSLOT-1:0]           pend;
  logic [NSLOT-1:0]           we;
  logic [NSLOT-1:0][TW-1:0]   tag_in;
  logic [NSLOT-1:0][21:0]     off;
  logic [21:0]                nxt_addr;
  logic                       dl;

  assign dl = bus.downloading;

  assign tag_in[GFX1] = TW'(bus.slot0_addr[SLOT0_AW-1:1]);
  assign tag_in[GFX2] = TW'(bus.slot1_addr[SLOT1_AW-1:1]);
  assign tag_in[SND]  = TW'(bus.slot2_addr[SLOT2_AW-1:1]);
  assign tag_in[MAIN] = TW'(bus.slot3_addr[SLOT3_AW-1:1]);

  assign off[GFX1] = SLOT0_OFFSET;
  assign off[GFX2] = SLOT1_OFFSET;
  assign off[SND]  = SLOT2_OFFSET;
  assign off[MAIN] = SLOT3_OFFSET;

`ifdef JTCONTRA_SCHED_RR_EN
  logic ptr;

  assign gfx_pick = (pend[GFX1] & pend[GFX2])
                  ? ptr : pend[GFX2];

  // Prefer the GFX slot that was not just served
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr <= 1'b0;
    end else if (fill && !win_q[1]) begin
      ptr <= ~win_q[0];
    end
  end
`else
  assign gfx_pick = ~pend[GFX1];
`endif

  always_comb begin
    win = {1'b0, gfx_pick};
    priority case (1'b1)
      pend[MAIN]: win = 2'(MAIN);
      pend[SND]:  win = 2'(SND);
      default:    win = {1'b0, gfx_pick};
    endcase
  end

  assign nxt_addr = off[win]
                  + 22'({tag_in[win], 1'b0});

  assign fill = (st == WAIT) & bus.data_rdy & ~dl;

  always_comb begin
    for (int i = 0; i < NSLOT; i++) begin
      we[i] = fill & (win_q == 2'(i));
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st     <= IDLE;
      req_q  <= 1'b0;
      addr_q <= '0;
      win_q  <= '0;
      tag_q  <= '0;
    end else if (dl) begin
      st    <= IDLE;
      req_q <= 1'b0;
    end else begin
      unique case (st)
        IDLE: if (|pend) begin
          st     <= REQ;
          req_q  <= 1'b1;
          win_q  <= win;
          tag_q  <= tag_in[win];
          addr_q <= nxt_addr;
        end
        REQ: if (bus.sdram_ack) begin
          st    <= WAIT;
          req_q <= 1'b0;
        end
        WAIT: if (bus.data_rdy) begin
          st <= IDLE;
        end
        default: st <= IDLE;
      endcase
    end
  end

  assign bus.sdram_req  = req_q & ~dl;
  assign bus.sdram_addr = addr_q;
  assign bus.refresh_en = bus.vblank & ~dl
                        & (st == IDLE) & ~|pend;

  jtcontra_sched_slot #(.AW(SLOT0_AW)) u_slot0 (
    .clk(clk), .rst(rst), .clr(dl),
    .we(we[GFX1]),
    .wr_tag(tag_q[SLOT0_AW-2:0]),
    .wr_data(bus.data_read),
    .cs(bus.slot0_cs), .addr(bus.slot0_addr),
    .ok(bus.slot0_ok), .dout(bus.slot0_dout),
    .pend(pend[GFX1])
  );

  jtcontra_sched_slot #(.AW(SLOT1_AW)) u_slot1 (
    .clk(clk), .rst(rst), .clr(dl),
    .we(we[GFX2]),
    .wr_tag(tag_q[SLOT1_AW-2:0]),
    .wr_data(bus.data_read),
    .cs(bus.slot1_cs), .addr(bus.slot1_addr),
    .ok(bus.slot1_ok), .dout(bus.slot1_dout),
    .pend(pend[GFX2])
  );

  jtcontra_sched_slot #(.AW(SLOT2_AW)) u_slot2 (
    .clk(clk), .rst(rst), .clr(dl),
    .we(we[SND]),
    .wr_tag(tag_q[SLOT2_AW-2:0]),
    .wr_data(bus.data_read),
    .cs(bus.slot2_cs), .addr(bus.slot2_addr),
    .ok(bus.slot2_ok), .dout(bus.slot2_dout),
    .pend(pend[SND])
  );

  jtcontra_sched_slot #(.AW(SLOT3_AW)) u_slot3 (
    .clk(clk), .rst(rst), .clr(dl),
    .we(we[MAIN]),
    .wr_tag(tag_q[SLOT3_AW-2:0]),
    .wr_data(bus.data_read),
    .cs(bus.slot3_cs), .addr(bus.slot3_addr),
    .ok(bus.slot3_ok), .dout(bus.slot3_dout),
    .pend(pend[MAIN])
  );
endmodule

// File: doc/jtcontra_rom_sched.md
# jtcontra_rom_sched

Four-slot SDRAM read scheduler for the Contra core. It sits between the ROM clients (main CPU, sound CPU, two GFX chips) and the single SDRAM read port, and holds a one-entry 32-bit cache per slot. It issues at most one SDRAM read at a time, with fixed priority for CPUs and shared arbitration between the GFX slots, and it gates refresh to idle vertical-blank time.

## Interface

Parameters:
- `SLOTn_AW` (n=0..3), default 18/18/15/18: slot address width, in 16-bit word units.
- `SLOTn_OFFSET` (n=0..3), default 0: 22-bit SDRAM word offset added to the slot address.

Ports (clock and reset first; one clock, reset asynchronous and active-high):
- `clk` in 1: system clock; all state is sampled on its rising edge.
- `rst` in 1: asynchronous, active-high reset.
- `vblank` in 1: high during vertical blank.
- `downloading` in 1: ROM download in progress.
- `slotn_cs` in 1: slot n read request (slot 0 = GFX1, 1 = GFX2, 2 = sound, 3 = main).
- `slotn_addr` in SLOTn_AW: slot n word address.
- `slotn_dout` out 16: slot n data.
- `slotn_ok` out 1: slot n data valid for the current address.
- `sdram_req` out 1: read request to the SDRAM controller.
- `sdram_addr` out 22: SDRAM word address of the read.
- `sdram_ack` in 1: controller accepted the request.
- `data_rdy` in 1: `data_read` is valid this cycle.
- `data_read` in 32: two 16-bit words; [15:0] is the even word, [31:16] the odd word.
- `refresh_en` out 1: controller may refresh.

## Operation

- Per-slot cache: `valid` bit, `tag` = addr[AW-1:1], 32-bit `data`.
- `slotn_ok` = cs & valid & (tag == slotn_addr[AW-1:1]). Combinational from registers.
- `slotn_dout` = addr[0] ? data[31:16] : data[15:0].
- A slot is pending when cs=1 and ok=0.
- Priority: slot 3 > slot 2 > GFX group. Within the GFX group, selection follows the configuration section.
- FSM has three states: IDLE, REQ, WAIT.
  - IDLE → REQ when any slot is pending and `downloading`=0. The winner index and its address tag are latched. `sdram_addr` = OFFSET + {tag,1'b0}, computed modulo 2^22.
  - REQ: `sdram_req`=1. → WAIT on the cycle `sdram_ack`=1; `sdram_req` drops on that same edge.
  - WAIT: on `data_rdy`=1, write the latched tag and data into the winner's cache, set `valid`, → IDLE.
- The latched tag is used for the cache write, not the live address. If a slot changes address mid-fetch, ok stays low and the slot requests again afterwards.
- `cs` dropping mid-fetch does not abort the fetch; the cache is still filled.
- `downloading`=1:
  - Clears every `valid` bit each cycle.
  - FSM is forced to IDLE. `sdram_req`=0.
  - All ok outputs are 0.
- `refresh_en` = vblank & IDLE & no slot pending. It is never asserted while `downloading`=1.
- `data_rdy` or `sdram_ack` arriving in IDLE is ignored.

## Timing

- Reset values:
  - Every output = 0: all `slotn_dout`, all `slotn_ok`, `sdram_req`, `sdram_addr`, `refresh_en`.
  - All `valid` = 0, FSM = IDLE, round-robin pointer = slot 0.
- Reset asserted mid-fetch: returns to IDLE immediately; a later `data_rdy` is ignored.
- Miss latency:
  - cs/addr presented before edge E; `sdram_req` high after E.
  - If `sdram_ack` is sampled at edge A and `data_rdy` at edge D, then ok=1 and dout are valid right after D.
  - Minimum is 3 edges from request to ok.
- Hit latency: zero. ok is valid combinationally in the cycle the address is presented.
- The other half of the same 32-bit word is a hit with no SDRAM access.
- Back-to-back reads: IDLE lasts one cycle between fetches when slots are pending.

## Configuration

- `JTCONTRA_SCHED_RR_EN` defined:
  - Slots 0 and 1 are served round-robin.
  - A 1-bit pointer names the preferred slot and moves to the other slot after each completed GFX fetch.
- Not defined: slot 0 always wins over slot 1.

## Structure

- Package `jtcontra_sched_pkg`: FSM state enum (IDLE, REQ, WAIT), slot-count constant (4), slot index constants (GFX1=0, GFX2=1, SND=2, MAIN=3).
- Sub-module `jtcontra_sched_slot`, instanced four times with AW as a parameter:
  - Holds valid/tag/data.
  - Performs hit compare and half-word select.
  - Takes write-enable and clear inputs from the scheduler FSM.

## Test plan

- Reset, then slot3 cs=1 at addr 0x00010:
  - Required: sdram_req=1 with sdram_addr=OFFSET3+0x10.
  - After ack and data_rdy with data_read=0xBEEF_1234: slot3_ok=1, dout=0x1234.
  - Changing addr to 0x00011 gives ok=1, dout=0xBEEF, and no new request.
- Slots 0, 2 and 3 all missing together:
  - Required grant order: 3, then 2, then 0.
  - Exactly one sdram_req pulse sequence per fetch.
- Slots 0 and 1 continuously missing, addresses bumped after each fill:
  - With RR_EN: grants alternate 0,1,0,1.
  - Without RR_EN: slot 1 is granted only when slot 0 cs=0.
- Slot 2 address changed while in WAIT:
  - Required: the fill uses the old tag, ok stays 0, and a second fetch for the new address follows.
- downloading=1 pulse after caches are filled:
  - Required: all ok=0, sdram_req=0, refresh_en=0.
  - After release, the next cs triggers a refetch.
- Async rst during REQ:
  - Required: sdram_req=0 immediately.
  - A subsequent data_rdy writes nothing and all ok stay 0.
- vblank=1 with no pending slots: refresh_en=1. A new miss drops refresh_en in the same cycle.
